// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the RV32I program loader: opcode values, instruction
// format codes, loader FSM states and the immediate range helper. The control
// decoder uses the same opcode constants, so both sides agree on one table.
package instr_encoder_loader_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S       = 7'b0100011;
  localparam logic [6:0] OPC_B       = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;

  // Request format codes on the fmt field; 9..15 are illegal
  localparam logic [3:0] FMT_R       = 4'd0;
  localparam logic [3:0] FMT_I_ARITH = 4'd1;
  localparam logic [3:0] FMT_I_LOAD  = 4'd2;
  localparam logic [3:0] FMT_S       = 4'd3;
  localparam logic [3:0] FMT_B       = 4'd4;
  localparam logic [3:0] FMT_JAL     = 4'd5;
  localparam logic [3:0] FMT_JALR    = 4'd6;
  localparam logic [3:0] FMT_AUIPC   = 4'd7;
  localparam logic [3:0] FMT_LUI     = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when imm is representable as a two's-complement value of 'bits' bits:
  // everything from bit (bits-1) upward must be a copy of the sign.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(imm) >>> (bits - 32'd1);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request / imem-write bundle of the program loader.
//   master : request source (start, finish, valid, fields) and consumer of the
//            imem write port and status
//   slave  : the loader itself
// start/finish/valid/fields -> loader; ready is the combinational accept;
// we/waddr/wdata form the registered imem write port; count/err/done are status.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic              start;
  logic              finish;
  logic              valid;
  logic              ready;
  logic [3:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              done;

  modport master (
    output start, finish, valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    input  ready, we, waddr, wdata, count, err, done
  );

  modport slave (
    input  start, finish, valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    output ready, we, waddr, wdata, count, err, done
  );

endinterface

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I packer: (format, register fields, funct, immediate) ->
// 32-bit instruction word plus an illegal flag.
//   fmt, rd, rs1, rs2, funct3, funct7, imm : request fields
//   word    : packed instruction, unused fields zero (zero for illegal fmt)
//   illegal : unknown format, immediate out of range, or misaligned offset
module instr_encoder_loader_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Format-specific bit placement and legality check
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, OPC_R};
      end
      FMT_I_ARITH: begin
        word    = {imm[11:0], rs1, funct3, rd, OPC_I_ARITH};
        illegal = ~imm_fits(imm, 32'd12);
      end
      FMT_I_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OPC_I_LOAD};
        illegal = ~imm_fits(imm, 32'd12);
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
        illegal = ~imm_fits(imm, 32'd12);
      end
      FMT_B: begin
        // Branch offsets are 13-bit signed and halfword aligned; bit 0 is implied
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_B};
        illegal = ~imm_fits(imm, 32'd13) | imm[0];
      end
      FMT_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = ~imm_fits(imm, 32'd21) | imm[0];
      end
      FMT_JALR: begin
        // funct3 of JALR is architecturally 000 whatever the request says
        word    = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        illegal = ~imm_fits(imm, 32'd12);
      end
      FMT_AUIPC: begin
        word    = {imm[31:12], rd, OPC_AUIPC};
        illegal = (imm[11:0] != 12'h000);
      end
      FMT_LUI: begin
        word    = {imm[31:12], rd, OPC_LUI};
        illegal = (imm[11:0] != 12'h000);
      end
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-side program loader: encodes accepted requests into RV32I words and
// writes them to instruction memory at BASE_ADDR + count, one word per cycle.
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus (slave)  : start/finish session control, valid/ready request handshake
//                  with instruction fields, registered imem write port
//                  (we/waddr/wdata), status count/err/done
// A request accepted in cycle N appears on the write port (or as an err pulse)
// in cycle N+1; count advances on that same edge.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  instr_encoder_loader_if.slave  bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] ZERO_C   = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

  state_t            state_r;
  state_t            state_n_s;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_n_s;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic              err_r;
  logic              done_r;

  logic              ready_s;
  logic              write_s;
  logic              reject_s;
  logic [31:0]       word_s;
  logic              illegal_s;

  instr_encoder_loader_pack u_pack (
    .fmt     (bus.fmt),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .imm     (bus.imm),
    .word    (word_s),
    .illegal (illegal_s)
  );

  // Handshake, write/reject decision, next count and next FSM state
  always_comb begin
    ready_s   = 1'b0;
    write_s   = 1'b0;
    reject_s  = 1'b0;
    count_n_s = count_r;
    state_n_s = state_r;

    // start/finish take the cycle for session control, so no accept alongside them
    ready_s  = (state_r == ST_LOAD) && (count_r < DEPTH_C) && !bus.start && !bus.finish;
    write_s  = bus.valid && ready_s && !illegal_s;
    reject_s = bus.valid && ready_s && illegal_s;

    if (bus.start) begin
      count_n_s = ZERO_C;
    end else if (write_s) begin
      count_n_s = count_r + ONE_C;
    end else begin
      count_n_s = count_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_n_s = ST_LOAD;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.start) begin
          state_n_s = ST_LOAD;
        end else if (bus.finish || (count_n_s == DEPTH_C)) begin
          // memory full: leave immediately so nothing can wrap onto BASE_ADDR
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_n_s = ST_LOAD;
        end else begin
          state_n_s = ST_DONE;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, count and registered output stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_C;
      we_r    <= 1'b0;
      waddr_r <= BASE_C;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      count_r <= count_n_s;
      we_r    <= write_s;
      err_r   <= reject_s;
      done_r  <= (state_n_s == ST_DONE);
      if (write_s) begin
        waddr_r <= BASE_C + count_r[ADDR_W-1:0];
        wdata_r <= word_s;
      end
    end
  end

  assign bus.ready = ready_s;
  assign bus.we    = we_r;
  assign bus.waddr = waddr_r;
  assign bus.wdata = wdata_r;
  assign bus.count = count_r;
  assign bus.err   = err_r;
  assign bus.done  = done_r;

endmodule
